// File: rtl/frequency_generator.sv
// Programmable square-wave source: converts a requested frequency into a
// half-period count with a sequential divider and retimes updates to period boundaries.
module frequency_generator #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int WIDTH    = 32
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Enable,
   input  logic [WIDTH-1:0] Freq_Set,
   input  logic             Set_Valid,
   output logic             Set_Ready,
   output logic             Err,
   output logic [WIDTH-1:0] Freq_Active,
   output logic             Fxout
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] DVD_INIT = WIDTH'(CLK_FREQ);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, DIVIDE, PENDING} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] fset_q, dvd_q, quo_q, h_q, pc_q, fact_q;
   logic [WIDTH:0]   rem_q;
   logic [BW-1:0]    bit_q;
   logic             fx_q, live_q, rdy_q, err_q;

   // Restoring division step: divisor is 2*Freq_Set, so the remainder needs WIDTH+1 bits.
   logic [WIDTH+1:0] trial, divisor, diff;
   logic             ge;
   logic [WIDTH:0]   rem_d;
   logic [WIDTH-1:0] quo_d;
   logic             pc_last;

   always_comb begin
      trial   = {rem_q, dvd_q[WIDTH-1]};
      divisor = {1'b0, fset_q, 1'b0};
      diff    = trial - divisor;
      ge      = (trial >= divisor);
      rem_d   = ge ? diff[WIDTH:0] : trial[WIDTH:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
      pc_last = (pc_q == h_q - ONE);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         fset_q  <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         bit_q   <= '0;
         h_q     <= '0;
         pc_q    <= '0;
         fact_q  <= '0;
         fx_q    <= 1'b0;
         live_q  <= 1'b0;
         rdy_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;

         // live_q marks an output already in its cycle; a fresh start rises immediately.
         if (!Enable) begin
            fx_q   <= 1'b0;
            pc_q   <= '0;
            live_q <= 1'b0;
         end else if (h_q != '0) begin
            if (!live_q) begin
               fx_q   <= 1'b1;
               pc_q   <= '0;
               live_q <= 1'b1;
            end else if (pc_last) begin
               fx_q <= ~fx_q;
               pc_q <= '0;
            end else begin
               pc_q <= pc_q + ONE;
            end
         end

         case (state_q)
            IDLE: begin
               if (Set_Valid) begin
                  fset_q  <= Freq_Set;
                  dvd_q   <= DVD_INIT;
                  rem_q   <= '0;
                  quo_q   <= '0;
                  bit_q   <= LAST_BIT;
                  rdy_q   <= 1'b0;
                  state_q <= DIVIDE;
               end
            end
            DIVIDE: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
               bit_q <= bit_q - BW'(1);
               if (bit_q == '0) begin
                  if (fset_q == '0) begin
                     fx_q    <= 1'b0;
                     pc_q    <= '0;
                     h_q     <= '0;
                     fact_q  <= '0;
                     live_q  <= 1'b0;
                     rdy_q   <= 1'b1;
                     state_q <= IDLE;
                  end else if (quo_d == '0) begin
                     err_q   <= 1'b1;
                     rdy_q   <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     state_q <= PENDING;
                  end
               end
            end
            PENDING: begin
               if (h_q == '0 || !Enable) begin
                  h_q     <= quo_q;
                  fact_q  <= fset_q;
                  pc_q    <= '0;
                  live_q  <= 1'b0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (live_q && !fx_q && pc_last) begin
                  // Swap on the low->high edge so the new high phase is full length.
                  fx_q    <= 1'b1;
                  h_q     <= quo_q;
                  fact_q  <= fset_q;
                  pc_q    <= '0;
                  rdy_q   <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Set_Ready   = rdy_q;
   assign Err         = err_q;
   assign Freq_Active = fact_q;
   assign Fxout       = fx_q;

endmodule

// File: doc/frequency_generator.md
Name: frequency_generator

Overview:
- Programmable square-wave source; the transmit-side counterpart of the frequency meter.
- Converts a requested frequency in Hz into a half-period count using an on-block sequential divider.
- Drives Fxout at that frequency from the system clock, applying updates glitch-free at period boundaries.
- Used as an on-board stimulus source feeding the meter's Fxin for self-test.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; must be at least 2.
- WIDTH, 32, width of the frequency word and of the internal counters.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Enable  input  1  1 = generate; 0 = Fxout forced low.
- Freq_Set  input  WIDTH  requested frequency in Hz.
- Set_Valid  input  1  request strobe; Freq_Set is sampled when Set_Valid && Set_Ready.
- Set_Ready  output  1  block can accept a new request.
- Err  output  1  one-cycle pulse when a request is rejected.
- Freq_Active  output  WIDTH  frequency currently applied (0 = stopped).
- Fxout  output  1  generated square wave, registered.

Behaviour:
- Reset (async, Rst_n=0): Fxout=0, Set_Ready=1, Err=0, Freq_Active=0, half-period H=0, phase counter=0, state IDLE.
- States: IDLE, DIVIDE, PENDING, with a separate RUN flag meaning H != 0.
- IDLE (Set_Ready=1): on Set_Valid, latch Freq_Set, drop Set_Ready next cycle, go to DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, exactly WIDTH cycles.
  - Computes Q = floor(CLK_FREQ / (2*Freq_Set)).
  - Divisor is WIDTH+1 bits wide; no overflow is permitted.
- End of DIVIDE, three cases:
  - Freq_Set == 0: apply stop immediately. Fxout=0, counter=0, H=0, Freq_Active=0. Go to IDLE.
  - Q == 0 (Freq_Set > CLK_FREQ/2): Err=1 for 1 cycle. H and Freq_Active unchanged. Go to IDLE.
  - Otherwise: go to PENDING holding Q.
- PENDING, output stopped (H==0) or Enable=0: apply next cycle. H=Q, Freq_Active=Freq_Set, counter=0. Go to IDLE.
- PENDING, output running: apply on the cycle the low phase expires, i.e. Fxout would go 0->1. Fxout goes high and the new H starts from counter=0. Go to IDLE.
- Set_Ready is low from the cycle after acceptance until the cycle after apply or reject. Set_Valid while Set_Ready=0 is ignored.
- Generation (Enable=1, H!=0):
  - Counter counts 0..H-1.
  - At H-1: toggle Fxout and clear the counter.
  - Period is 2*H clocks, 50% duty.
  - First edge after starting from stopped is 0->1, 1 cycle after apply.
- Enable=0: Fxout=0 and counter=0 the next cycle. H, Freq_Active and any in-flight DIVIDE/PENDING are preserved.
- Enable 0->1 with H!=0: Fxout goes high the next cycle, counter=0.
- Realised frequency is CLK_FREQ/(2*H). Freq_Active reports the request, not the rounded value.
- Reset mid-DIVIDE or mid-PENDING: the request is discarded and all values return to their reset values.

Test Plan (CLK_FREQ=1000, WIDTH=16 unless stated):
- Reset, Enable=1, request 100. Set_Ready low 17-18 cycles. Fxout starts high, 5 clk high / 5 clk low repeating. Freq_Active=100.
- While running at 100, request 3 (Q=166).
  - Current period completes unchanged.
  - Switch occurs exactly at a 0->1 edge; the next high phase is 166 clocks. No runt pulse.
- Request 600 (> 500). Err pulses for exactly 1 cycle. Output stays at previous frequency and Freq_Active unchanged. Set_Ready returns high.
- Request 0 while running. Fxout=0 and Freq_Active=0 right after DIVIDE. Then request 500: H=1, Fxout toggles every clock.
- Drop Enable mid-high-phase. Fxout low next cycle. Raise Enable: high next cycle, full 5-clock high phase at 100 Hz.
- Assert Rst_n=0 at DIVIDE cycle 8. All outputs at reset values. Set_Ready=1 after release. Fxout stays 0 with no request.
